// File: rtl/timer_io_if.sv
// timer_io_if: memory-mapped bus between a CPU-side master and the timer_io
// peripheral.
//   we    : write strobe, qualified by addr
//   addr  : word index (0 CTRL, 1 COUNT, 2 COMPARE, 3 STATUS)
//   wdata : write data
//   rdata : read data, combinational from addr
//   irq   : interrupt request from the peripheral
interface timer_io_if;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (output we, addr, wdata, input rdata, irq);
  modport slave  (input we, addr, wdata, output rdata, irq);
endinterface

// File: rtl/timer_io.sv
// timer_io: memory-mapped tick timer.
// The system clock is divided by DIV = CLK_FREQ_HZ / TICK_HZ into ticks.
// Each tick advances a 32-bit COUNT. COUNT == COMPARE on a tick sets
// STATUS.match and can optionally reload COUNT to 0.
//
// Ports:
//   clk   : system clock, all state on the rising edge
//   reset : asynchronous, active-high, clears all state
//   bus   : timer_io_if.slave (we, addr, wdata in; rdata, irq out)
//
// Register map (word index):
//   0 CTRL    bit0 run, bit1 irq_en, bit2 auto_reload, bit3 oneshot
//   1 COUNT   tick count, writable
//   2 COMPARE match value
//   3 STATUS  bit0 match, write 1 to clear
//
// Optional feature macro TIMER_IO_ONESHOT_EN: when defined, CTRL bit3 is
// stored, and a match with oneshot=1 stops the timer. When it is undefined,
// bit3 reads 0 and the timer is always free-running.
module timer_io #(
  parameter int CLK_FREQ_HZ = 1000000,
  parameter int TICK_HZ     = 1000
) (
  input  logic      clk,
  input  logic      reset,
  timer_io_if.slave bus
);

  localparam int DIV = (TICK_HZ > 0) ? CLK_FREQ_HZ / TICK_HZ : 0;
  localparam int REM = (TICK_HZ > 0) ? CLK_FREQ_HZ % TICK_HZ : 1;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  generate
    if (TICK_HZ <= 0 || DIV < 1 || REM != 0) begin : g_bad_div
      $error("timer_io: CLK_FREQ_HZ/TICK_HZ must be an integer >= 1");
    end
  endgenerate

  logic          ctrl_run;
  logic          ctrl_irq_en;
  logic          ctrl_auto_reload;
  logic          ctrl_oneshot;
  logic [31:0]   count;
  logic [31:0]   compare;
  logic          status_match;
  logic [PW-1:0] pre;

  logic wr_ctrl, wr_count, wr_compare, wr_status;
  logic tick, match_ev;

`ifndef TIMER_IO_ONESHOT_EN
  assign ctrl_oneshot = 1'b0;
`endif

  assign wr_ctrl    = bus.we && (bus.addr == 2'd0);
  assign wr_count   = bus.we && (bus.addr == 2'd1);
  assign wr_compare = bus.we && (bus.addr == 2'd2);
  assign wr_status  = bus.we && (bus.addr == 2'd3);

  // The compare uses the COMPARE value held before this edge, so a COMPARE
  // write landing on a match edge does not affect that match.
  assign tick     = ctrl_run && (pre == PRE_MAX);
  assign match_ev = tick && (count == compare);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_run         <= 1'b0;
      ctrl_irq_en      <= 1'b0;
      ctrl_auto_reload <= 1'b0;
`ifdef TIMER_IO_ONESHOT_EN
      ctrl_oneshot     <= 1'b0;
`endif
      count            <= '0;
      compare          <= '0;
      status_match     <= 1'b0;
      pre              <= '0;
    end else begin
      // Prescaler keeps running across COUNT writes; a stopped timer parks it
      // at 0 so the first tick after a restart is a full DIV edges away.
      if (!ctrl_run || pre == PRE_MAX) pre <= '0;
      else                             pre <= pre + 1'b1;

      if (wr_ctrl) begin
        ctrl_run         <= bus.wdata[0];
        ctrl_irq_en      <= bus.wdata[1];
        ctrl_auto_reload <= bus.wdata[2];
`ifdef TIMER_IO_ONESHOT_EN
        ctrl_oneshot     <= bus.wdata[3];
`endif
      end
`ifdef TIMER_IO_ONESHOT_EN
      if (match_ev && ctrl_oneshot) ctrl_run <= 1'b0;
`endif

      if (wr_count)                           count <= bus.wdata;
      else if (match_ev && ctrl_auto_reload)  count <= '0;
      else if (tick)                          count <= count + 32'd1;

      if (wr_compare) compare <= bus.wdata;

      // Setting on a match outranks a simultaneous write-1-to-clear.
      if (match_ev)                       status_match <= 1'b1;
      else if (wr_status && bus.wdata[0]) status_match <= 1'b0;
    end
  end

  always_comb begin
    bus.rdata = '0;
    case (bus.addr)
      2'd0:    bus.rdata = {28'd0, ctrl_oneshot, ctrl_auto_reload, ctrl_irq_en, ctrl_run};
      2'd1:    bus.rdata = count;
      2'd2:    bus.rdata = compare;
      default: bus.rdata = {31'd0, status_match};
    endcase
  end

  assign bus.irq = status_match && ctrl_irq_en;

endmodule
